// File: rtl/ip_tx_arbiter_if.sv
// Signal bundle between ip_tx_arbiter, its two requesters and the packet transmitter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface ip_tx_arbiter_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   req0_valid;
  logic                   req1_valid;
  logic [31:0]            req0_ip_address;
  logic [31:0]            req1_ip_address;
  logic [47:0]            req0_mac_address;
  logic [47:0]            req1_mac_address;
  logic [9:0]             req0_message;
  logic [9:0]             req1_message;
  logic                   req0_ready;
  logic                   req1_ready;
  logic                   req0_done;
  logic                   req1_done;
  logic [31:0]            recipient_ip_address;
  logic [47:0]            recipient_mac_address;
  logic [9:0]             recipient_message;
  logic                   start_ip_txn;
  logic                   ready_for_send;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] tx_count;
  logic                   txn_error;

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_ip_address, req1_ip_address,
    input  req0_mac_address, req1_mac_address,
    input  req0_message, req1_message,
    input  ready_for_send,
    output req0_ready, req1_ready, req0_done, req1_done,
    output recipient_ip_address, recipient_mac_address, recipient_message,
    output start_ip_txn, busy, tx_count, txn_error
  );

  modport master (
    output req0_valid, req1_valid,
    output req0_ip_address, req1_ip_address,
    output req0_mac_address, req1_mac_address,
    output req0_message, req1_message,
    output ready_for_send,
    input  req0_ready, req1_ready, req0_done, req1_done,
    input  recipient_ip_address, recipient_mac_address, recipient_message,
    input  start_ip_txn, busy, tx_count, txn_error
  );
endinterface

// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter feeding one packet transmitter from two requesters,
// with a start-timeout watchdog and a completed-packet counter.
module ip_tx_arbiter #(
  parameter int START_TIMEOUT = 8,
  parameter int COUNT_WIDTH   = 16
) (
  input logic            aclk_i,
  input logic            areset_i,
  ip_tx_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam int               TMO_W    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

  logic [1:0]             state_q, state_d;
  logic                   last_q, last_d;
  logic                   owner_q, owner_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [31:0]            ip_q, ip_d;
  logic [47:0]            mac_q, mac_d;
  logic [9:0]             msg_q, msg_d;
  logic                   done0_q, done0_d;
  logic                   done1_q, done1_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   err_q, err_d;
  logic                   grant;
  logic                   sel;

  // On a tie the requester that did not win last time is chosen; reset is
  // masked here so no accept can leak through a reset cycle.
  always_comb begin
    sel   = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
    grant = !areset_i && (state_q == IDLE) && bus.ready_for_send &&
            (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready = grant & ~sel;
  assign bus.req1_ready = grant &  sel;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    tmo_d   = tmo_q;
    ip_d    = ip_q;
    mac_d   = mac_q;
    msg_d   = msg_q;
    count_d = count_q;
    err_d   = err_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = LAUNCH;
          last_d  = sel;
          owner_d = sel;
          ip_d    = sel ? bus.req1_ip_address  : bus.req0_ip_address;
          mac_d   = sel ? bus.req1_mac_address : bus.req0_mac_address;
          msg_d   = sel ? bus.req1_message     : bus.req0_message;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.ready_for_send) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.ready_for_send) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      tmo_q   <= '0;
      ip_q    <= '0;
      mac_q   <= '0;
      msg_q   <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      tmo_q   <= tmo_d;
      ip_q    <= ip_d;
      mac_q   <= mac_d;
      msg_q   <= msg_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.req0_done             = done0_q;
  assign bus.req1_done             = done1_q;
  assign bus.recipient_ip_address  = ip_q;
  assign bus.recipient_mac_address = mac_q;
  assign bus.recipient_message     = msg_q;
  assign bus.start_ip_txn          = (state_q == LAUNCH);
  assign bus.busy                  = (state_q != IDLE);
  assign bus.tx_count              = count_q;
  assign bus.txn_error             = err_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Bench for ip_tx_arbiter: transaction-timing reference model checked every cycle,
// a table of grant vectors, directed corner sequences and a randomized phase.
module tb_ip_tx_arbiter;

  localparam int T_OUT = 8;

  typedef struct {
    bit v0;
    bit v1;
    int len;
    int expGrant;
    int expCount;
  } vec_t;

  logic aclk = 1'b0;
  logic areset;

  always #5 aclk = ~aclk;

  ip_tx_arbiter_if #(.COUNT_WIDTH(16)) bus ();
  ip_tx_arbiter_if #(.COUNT_WIDTH(2))  bus2 ();

  assign bus2.req0_valid       = bus.req0_valid;
  assign bus2.req1_valid       = bus.req1_valid;
  assign bus2.req0_ip_address  = bus.req0_ip_address;
  assign bus2.req1_ip_address  = bus.req1_ip_address;
  assign bus2.req0_mac_address = bus.req0_mac_address;
  assign bus2.req1_mac_address = bus.req1_mac_address;
  assign bus2.req0_message     = bus.req0_message;
  assign bus2.req1_message     = bus.req1_message;
  assign bus2.ready_for_send   = bus.ready_for_send;

  ip_tx_arbiter #(.START_TIMEOUT(T_OUT), .COUNT_WIDTH(16)) dut (
    .aclk_i   (aclk),
    .areset_i (areset),
    .bus      (bus)
  );

  ip_tx_arbiter #(.START_TIMEOUT(T_OUT), .COUNT_WIDTH(2)) dutNarrow (
    .aclk_i   (aclk),
    .areset_i (areset),
    .bus      (bus2)
  );

  int nCompared   = 0;
  int nMismatched = 0;
  int t           = 0;

  bit xmitAuto  = 1'b0;
  int xmitLen   = 1;
  int xmitLeft  = 0;
  bit startSeen = 1'b0;
  bit sawReady0 = 1'b0;
  bit sawReady1 = 1'b0;

  // Reference model: a transaction is described by its accept cycle and by
  // whether the transmitter has been seen busy yet; everything else follows.
  bit              mInFlight;
  bit              mLast;
  bit              mOwner;
  bit              mFell;
  bit              mErr;
  bit              mAccepted;
  bit              mDoneOwner;
  int              mAcceptCycle;
  int              mDoneCycle;
  longint unsigned mCount;
  logic [31:0]     mIp;
  logic [47:0]     mMac;
  logic [9:0]      mMsg;

  task automatic modelReset();
    mInFlight  = 1'b0;
    mLast      = 1'b1;
    mOwner     = 1'b0;
    mFell      = 1'b0;
    mErr       = 1'b0;
    mDoneOwner = 1'b0;
    mDoneCycle = -100;
    mCount     = 0;
    mIp        = '0;
    mMac       = '0;
    mMsg       = '0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, t, actual, expected);
    end
  endtask

  task automatic failNote(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s at cycle %0d: wait budget expired", name, t);
  endtask

  task automatic applyStimulus();
    bit any;
    bit g;
    bit gr;
    #1;
    any = bus.req0_valid | bus.req1_valid;
    g   = (bus.req0_valid && bus.req1_valid) ? !mLast : bus.req1_valid;
    gr  = !areset && !mInFlight && bus.ready_for_send && any;

    checkOutput("req0_ready", bus.req0_ready, gr && !g);
    checkOutput("req1_ready", bus.req1_ready, gr && g);
    checkOutput("busy", bus.busy, mInFlight);
    checkOutput("start_ip_txn", bus.start_ip_txn, mInFlight && (t == mAcceptCycle + 1));
    checkOutput("req0_done", bus.req0_done, (t == mDoneCycle) && !mDoneOwner);
    checkOutput("req1_done", bus.req1_done, (t == mDoneCycle) && mDoneOwner);
    checkOutput("recipient_ip", bus.recipient_ip_address, mIp);
    checkOutput("recipient_mac", bus.recipient_mac_address, mMac);
    checkOutput("recipient_msg", bus.recipient_message, mMsg);
    checkOutput("tx_count", bus.tx_count, mCount[15:0]);
    checkOutput("tx_count_w2", bus2.tx_count, mCount[1:0]);
    checkOutput("txn_error", bus.txn_error, mErr);

    sawReady0 = bus.req0_ready;
    sawReady1 = bus.req1_ready;
    startSeen = bus.start_ip_txn;

    mAccepted = 1'b0;
    if (areset) begin
      modelReset();
    end else if (!mInFlight) begin
      if (gr) begin
        mInFlight    = 1'b1;
        mAccepted    = 1'b1;
        mAcceptCycle = t;
        mOwner       = g;
        mLast        = g;
        mFell        = 1'b0;
        mIp          = g ? bus.req1_ip_address  : bus.req0_ip_address;
        mMac         = g ? bus.req1_mac_address : bus.req0_mac_address;
        mMsg         = g ? bus.req1_message     : bus.req0_message;
      end
    end else if (t >= mAcceptCycle + 2) begin
      if (!mFell) begin
        if (!bus.ready_for_send) begin
          mFell = 1'b1;
        end else if (t - mAcceptCycle - 1 == T_OUT) begin
          mErr      = 1'b1;
          mInFlight = 1'b0;
        end
      end else if (bus.ready_for_send) begin
        mDoneCycle = t + 1;
        mDoneOwner = mOwner;
        mCount++;
        mInFlight = 1'b0;
      end
    end

    @(posedge aclk);
    #1;
    t++;
    if (xmitAuto) begin
      if (startSeen) begin
        bus.ready_for_send = 1'b0;
        xmitLeft           = xmitLen;
      end else if (xmitLeft > 0) begin
        xmitLeft--;
        if (xmitLeft == 0) bus.ready_for_send = 1'b1;
      end
    end
  endtask

  task automatic randomData();
    bus.req0_ip_address  = $urandom;
    bus.req1_ip_address  = $urandom;
    bus.req0_mac_address = {16'($urandom), $urandom};
    bus.req1_mac_address = {16'($urandom), $urandom};
    bus.req0_message     = 10'($urandom);
    bus.req1_message     = 10'($urandom);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while (mInFlight && n < budget) begin
      applyStimulus();
      n++;
    end
    if (mInFlight) failNote(name);
  endtask

  // Request data is scrambled right after accept to show the captured values hold.
  task automatic runTxn(input bit v0, input bit v1, input int len, output int granted);
    int n;
    granted        = -1;
    xmitAuto       = 1'b1;
    xmitLen        = len;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    randomData();
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!mAccepted && n < 100);
    if (!mAccepted) begin
      failNote("txn_accept");
      return;
    end
    granted = sawReady1 ? 1 : (sawReady0 ? 0 : -1);
    randomData();
    waitIdle("txn_complete", 200);
  endtask

  initial begin
    vec_t tbl[8];
    int   wrapSeq[5];
    int   g;
    int   acc;

    tbl[0] = '{v0: 1'b1, v1: 1'b1, len: 3, expGrant: 0, expCount: 1};
    tbl[1] = '{v0: 1'b1, v1: 1'b1, len: 1, expGrant: 1, expCount: 2};
    tbl[2] = '{v0: 1'b1, v1: 1'b1, len: 5, expGrant: 0, expCount: 3};
    tbl[3] = '{v0: 1'b1, v1: 1'b1, len: 2, expGrant: 1, expCount: 4};
    tbl[4] = '{v0: 1'b1, v1: 1'b0, len: 4, expGrant: 0, expCount: 5};
    tbl[5] = '{v0: 1'b1, v1: 1'b1, len: 1, expGrant: 1, expCount: 6};
    tbl[6] = '{v0: 1'b0, v1: 1'b1, len: 2, expGrant: 1, expCount: 7};
    tbl[7] = '{v0: 1'b1, v1: 1'b1, len: 3, expGrant: 0, expCount: 8};
    wrapSeq = '{1, 2, 3, 0, 1};

    areset             = 1'b1;
    bus.req0_valid     = 1'b0;
    bus.req1_valid     = 1'b0;
    bus.ready_for_send = 1'b1;
    randomData();
    modelReset();
    @(posedge aclk);
    #1;
    applyStimulus();
    areset = 1'b0;

    // Single requester 0 with a 34-cycle transmitter.
    bus.req0_valid       = 1'b1;
    bus.req0_ip_address  = 32'hdeadbeef;
    bus.req0_mac_address = 48'h32dabbadebd5;
    bus.req0_message     = 10'h1ff;
    xmitAuto             = 1'b1;
    xmitLen              = 34;
    xmitLeft             = 0;
    acc                  = t;
    applyStimulus();
    checkOutput("r032_ready0", sawReady0, 1);
    bus.req0_valid      = 1'b0;
    bus.req0_ip_address = 32'h0;
    #1;
    checkOutput("r032_start", bus.start_ip_txn, 1);
    checkOutput("r032_ip", bus.recipient_ip_address, 32'hdeadbeef);
    checkOutput("r032_mac", bus.recipient_mac_address, 48'h32dabbadebd5);
    checkOutput("r032_msg", bus.recipient_message, 10'h1ff);
    waitIdle("r032_complete", 100);
    checkOutput("r032_done_cycle", t - acc, 37);
    checkOutput("r032_done0", bus.req0_done, 1);
    checkOutput("r032_count", bus.tx_count, 1);

    // Grant table from a fresh reset; valids stay up into each DONE cycle.
    areset = 1'b1;
    applyStimulus();
    areset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      runTxn(tbl[i].v0, tbl[i].v1, tbl[i].len, g);
      checkOutput("tbl_grant", g, tbl[i].expGrant);
      checkOutput("tbl_count", bus.tx_count, tbl[i].expCount);
      checkOutput("tbl_done", (tbl[i].expGrant == 1) ? bus.req1_done : bus.req0_done, 1);
    end

    // Transmitter not idle: requester 1 must wait.
    bus.req0_valid     = 1'b0;
    bus.req1_valid     = 1'b1;
    xmitAuto           = 1'b0;
    bus.ready_for_send = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("r034_hold_ready1", sawReady1, 0);
    end
    bus.ready_for_send = 1'b1;
    xmitAuto           = 1'b1;
    xmitLen            = 3;
    xmitLeft           = 0;
    applyStimulus();
    checkOutput("r034_ready1", sawReady1, 1);
    bus.req1_valid = 1'b0;
    waitIdle("r034_complete", 50);

    // Transmitter never goes busy: start timeout.
    xmitAuto           = 1'b0;
    xmitLeft           = 0;
    bus.ready_for_send = 1'b1;
    bus.req0_valid     = 1'b1;
    acc                = t;
    applyStimulus();
    bus.req0_valid = 1'b0;
    waitIdle("r035_timeout", 50);
    checkOutput("r035_latency", t - acc, T_OUT + 2);
    checkOutput("r035_error", bus.txn_error, 1);
    checkOutput("r035_busy", bus.busy, 0);
    checkOutput("r035_done", {bus.req1_done, bus.req0_done}, 0);
    checkOutput("r035_count", bus.tx_count, 9);
    runTxn(1'b0, 1'b1, 2, g);
    checkOutput("r035_next_grant", g, 1);
    checkOutput("r035_next_count", bus.tx_count, 10);
    checkOutput("r035_sticky", bus.txn_error, 1);

    // Reset while waiting for the transmitter to finish.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b0;
    xmitAuto       = 1'b1;
    xmitLen        = 10;
    applyStimulus();
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("r036_in_wait_done", bus.ready_for_send, 0);
    areset = 1'b1;
    applyStimulus();
    areset = 1'b0;
    checkOutput("r036_busy", bus.busy, 0);
    checkOutput("r036_count", bus.tx_count, 0);
    checkOutput("r036_error", bus.txn_error, 0);
    checkOutput("r036_ip", bus.recipient_ip_address, 0);
    checkOutput("r036_done", {bus.req1_done, bus.req0_done}, 0);
    runTxn(1'b0, 1'b1, 2, g);
    checkOutput("r036_req1_grant", g, 1);
    checkOutput("r036_req1_done", bus.req1_done, 1);
    checkOutput("r036_req1_count", bus.tx_count, 1);

    // Narrow counter wraps modulo 4.
    areset = 1'b1;
    applyStimulus();
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      runTxn(1'b1, 1'b0, 1 + i, g);
      checkOutput("r037_count_w2", bus2.tx_count, wrapSeq[i]);
      checkOutput("r037_count_w16", bus.tx_count, i + 1);
    end

    // Randomized traffic, transmitter behaviour and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) begin
        xmitAuto = ($urandom_range(0, 3) != 0);
        xmitLen  = $urandom_range(1, 6);
        if (xmitAuto) begin
          bus.ready_for_send = 1'b1;
          xmitLeft           = 0;
        end
      end
      bus.req0_valid = ($urandom_range(0, 2) == 0);
      bus.req1_valid = ($urandom_range(0, 2) == 0);
      randomData();
      if (!xmitAuto) bus.ready_for_send = ($urandom_range(0, 9) != 0);
      areset = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end
    areset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ip_tx_arbiter.md
IP_TX_ARBITER -- requirements
Module: ip_tx_arbiter

Interface
REQ-001 Parameter START_TIMEOUT, default 8: max cycles after START_IP_TXN for READY_FOR_SEND to fall.
REQ-002 Parameter COUNT_WIDTH, default 16: width of TX_COUNT.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESET  in  1  reset, synchronous, active-high.
REQ-005 REQ0_VALID / REQ1_VALID  in  1 each  requester 0 (load-balancer response) / requester 1 (inference result) has a packet pending.
REQ-006 REQ0_IP_ADDRESS / REQ1_IP_ADDRESS  in  32 each  destination IP.
REQ-007 REQ0_MAC_ADDRESS / REQ1_MAC_ADDRESS  in  48 each  destination MAC.
REQ-008 REQ0_MESSAGE / REQ1_MESSAGE  in  10 each  payload.
REQ-009 REQ0_READY / REQ1_READY  out  1 each  request accepted this cycle.
REQ-010 REQ0_DONE / REQ1_DONE  out  1 each  one-cycle pulse: that requester's packet fully sent.
REQ-011 RECIPIENT_IP_ADDRESS / RECIPIENT_MAC_ADDRESS / RECIPIENT_MESSAGE  out  32/48/10  to packet transmitter.
REQ-012 START_IP_TXN  out  1  start pulse to packet transmitter.
REQ-013 READY_FOR_SEND  in  1  transmitter idle (high) / sending (low).
REQ-014 BUSY  out  1  high in any state other than IDLE.
REQ-015 TX_COUNT  out  COUNT_WIDTH  completed packets.
REQ-016 TXN_ERROR  out  1  sticky start-timeout flag.

Function
REQ-017 States IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE; BUSY = (state != IDLE).
REQ-018 IDLE: if READY_FOR_SEND=1 and any REQx_VALID=1, grant one requester g; REQg_READY=1 combinationally that cycle; capture REQg address/MAC/message into RECIPIENT_* registers; next state LAUNCH.
REQ-019 REQx_READY is 0 in every state except IDLE; never both 1; never 1 while REQx_VALID=0.
REQ-020 IDLE with READY_FOR_SEND=0: no grant, stay IDLE.
REQ-021 Arbitration round-robin: one valid -> grant it; both valid -> grant the requester not granted last; last-grant pointer updates only on accept; reset pointer = 1, so requester 0 wins the first tie.
REQ-022 LAUNCH: START_IP_TXN=1 exactly one cycle (accept cycle N -> START at N+1); clear timeout counter; next WAIT_BUSY.
REQ-023 WAIT_BUSY: READY_FOR_SEND=0 -> WAIT_DONE; else counter increments; when counter reaches START_TIMEOUT with READY_FOR_SEND still 1 -> set TXN_ERROR, go IDLE, no DONE, TX_COUNT unchanged.
REQ-024 WAIT_DONE: READY_FOR_SEND=1 -> registered REQg_DONE=1 for one cycle, TX_COUNT+1 (wraps modulo 2^COUNT_WIDTH), next IDLE.
REQ-025 DONE pulse is coincident with the first IDLE cycle; a new accept is allowed in that same cycle.
REQ-026 RECIPIENT_* stable from capture until next accept; hold last values while idle.
REQ-027 START_IP_TXN=0 outside LAUNCH; at most one transaction outstanding.
REQ-028 Requester input changes after accept have no effect on the transaction in flight.
REQ-029 TXN_ERROR cleared only by reset.

Reset
REQ-030 ARESET=1 at a clock edge: state IDLE, pointer 1, all outputs 0 (READY, DONE, START_IP_TXN, BUSY, RECIPIENT_*, TX_COUNT, TXN_ERROR); applies mid-transaction, abandoning it without DONE.
REQ-031 ARESET overrides every other input in the same cycle.

Verification
REQ-032 REQ0 only (IP 0xdeadbeef, MAC 0x32dabbadebd5, msg 0x1ff), transmitter model busy 34 cycles -> READY0 at N, START at N+1 with those RECIPIENT_* values, DONE0 one cycle after READY_FOR_SEND rises, TX_COUNT=1.
REQ-033 REQ0 and REQ1 both valid continuously for 4 packets -> grant order 0,1,0,1; no overlapping STARTs; TX_COUNT=4.
REQ-034 REQ1 valid while READY_FOR_SEND=0 in IDLE -> no READY1 until READY_FOR_SEND=1.
REQ-035 READY_FOR_SEND held at 1 after START -> TXN_ERROR=1 after 8 cycles, state IDLE, no DONE, TX_COUNT unchanged; next request still served.
REQ-036 ARESET asserted during WAIT_DONE -> next cycle all outputs 0, no DONE; following REQ1 request completes normally.
REQ-037 TX_COUNT preset path (COUNT_WIDTH=2), 5 packets -> TX_COUNT sequence 1,2,3,0,1.
